// File: rtl/icache_pkg.sv
// icache_pkg: shared types and address helpers for the instruction cache.
// Provides the fetch FSM state enum, default geometry with derived widths,
// and functions that split a byte address into offset / index / tag fields.
package icache_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REFILL = 2'd1,
    REPLAY = 2'd2
  } state_t;

  // Field widths for a given geometry; bits [1:0] are the byte-in-word.
  function automatic int unsigned off_width(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned sets, input int unsigned line_words);
    return 30 - $clog2(sets) - $clog2(line_words);
  endfunction

  localparam int unsigned ICACHE_SETS       = 64;
  localparam int unsigned ICACHE_LINE_WORDS = 4;
  localparam logic [31:0] ICACHE_RESET_ADDR = 32'h0000_1000;
  localparam int unsigned OFF_W = off_width(ICACHE_LINE_WORDS);
  localparam int unsigned IDX_W = idx_width(ICACHE_SETS);
  localparam int unsigned TAG_W = tag_width(ICACHE_SETS, ICACHE_LINE_WORDS);

  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int unsigned ow);
    return (a >> 2) & ((32'd1 << ow) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned ow,
                                             input int unsigned iw);
    return (a >> (2 + ow)) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned ow,
                                           input int unsigned iw);
    return a >> (2 + ow + iw);
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a, input int unsigned ow);
    return a & ~((32'd1 << (2 + ow)) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_fetch_if.sv
// icache_fetch_if: instruction memory read bus (req/ack handshake).
// master = cache side (drives mem_req, word-aligned mem_addr);
// slave = memory side (returns mem_rdata with mem_ack for the current mem_addr).
interface icache_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/icache_line_ram.sv
// icache_line_ram: data + tag storage for a direct-mapped cache, synchronous read.
// Ports: CLK; read port rd_en/rd_idx/rd_off -> rd_word/rd_tag (valid next cycle,
// held while rd_en=0); write port wr_en/wr_idx/wr_off/wr_word, tag_we/tag_wdata at wr_idx.
module icache_line_ram #(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TW         = 22
) (
  input  logic                          CLK,
  input  logic                          rd_en,
  input  logic [$clog2(SETS)-1:0]       rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_off,
  output logic [31:0]                   rd_word,
  output logic [TW-1:0]                 rd_tag,
  input  logic                          wr_en,
  input  logic [$clog2(SETS)-1:0]       wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
  input  logic [31:0]                   wr_word,
  input  logic                          tag_we,
  input  logic [TW-1:0]                 tag_wdata
);

  // Word storage is flattened as {index, offset}.
  logic [31:0]   data_mem [SETS*LINE_WORDS];
  logic [TW-1:0] tag_mem  [SETS];

  always_ff @(posedge CLK) begin
    if (wr_en) data_mem[{wr_idx, wr_off}] <= wr_word;
    if (tag_we) tag_mem[wr_idx] <= tag_wdata;
    if (rd_en) begin
      rd_word <= data_mem[{rd_idx, rd_off}];
      rd_tag  <= tag_mem[rd_idx];
    end
  end

endmodule

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped instruction cache responder for the core fetch port.
// Ports: CLK, resetn (async, active-low); fetch_addr/fetch_enable in; instr_fetch/
// fetch_valid/busy out; mem (icache_fetch_if.master) refill bus. Hit latency 1 cycle.
// Optional macro ICACHE_PERF_EN adds hit_count/miss_count outputs.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int unsigned SETS       = ICACHE_SETS,
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
  parameter logic [31:0] RESET_ADDR = ICACHE_RESET_ADDR
) (
  input  logic          CLK,
  input  logic          resetn,
  input  logic [31:0]   fetch_addr,
  input  logic          fetch_enable,
  output logic [31:0]   instr_fetch,
  output logic          fetch_valid,
  output logic          busy,
  icache_fetch_if.master mem
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int unsigned OW = off_width(LINE_WORDS);
  localparam int unsigned IW = idx_width(SETS);
  localparam int unsigned TW = tag_width(SETS, LINE_WORDS);

  state_t          state, state_nxt;
  logic            req_q;
  logic [31:0]     addr_q;
  logic [OW-1:0]   beat;
  logic [SETS-1:0] valid_q;
  logic [31:0]     instr_q;

  logic [IW-1:0]   q_idx, f_idx, rd_idx;
  logic [OW-1:0]   q_off, f_off, rd_off;
  logic [TW-1:0]   q_tag, rd_tag;
  logic [31:0]     rd_word;
  logic            rd_en, hit, miss, ack_take, last_beat;

  assign q_idx = IW'(addr_index(addr_q, OW, IW));
  assign q_off = OW'(addr_offset(addr_q, OW));
  assign q_tag = TW'(addr_tag(addr_q, OW, IW));
  assign f_idx = IW'(addr_index(fetch_addr, OW, IW));
  assign f_off = OW'(addr_offset(fetch_addr, OW));

  assign hit       = valid_q[q_idx] && (rd_tag == q_tag);
  // mem_req is high for the whole of REFILL, so acks outside it are ignored here.
  assign ack_take  = (state == REFILL) && mem.mem_ack;
  assign last_beat = ack_take && (beat == OW'(LINE_WORDS - 1));

  // On a hit the word comes straight from the RAM output; otherwise the last hit holds.
  assign instr_fetch = fetch_valid ? rd_word : instr_q;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fetch_valid = 1'b0;
    miss        = 1'b0;
    busy        = 1'b0;
    rd_en       = 1'b0;
    rd_idx      = f_idx;
    rd_off      = f_off;
    case (state)
      RUN: begin
        rd_en = fetch_enable;
        if (req_q) begin
          if (hit) begin
            fetch_valid = 1'b1;
          end else begin
            miss      = 1'b1;
            state_nxt = REFILL;
          end
        end
      end
      REFILL: begin
        busy = 1'b1;
        if (last_beat) state_nxt = REPLAY;
      end
      REPLAY: begin
        // Re-read the freshly filled line so the next RUN cycle compares as a hit.
        busy      = 1'b1;
        rd_en     = 1'b1;
        rd_idx    = q_idx;
        rd_off    = q_off;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      req_q        <= 1'b1;
      addr_q       <= RESET_ADDR;
      beat         <= '0;
      valid_q      <= '0;
      instr_q      <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      case (state)
        RUN: begin
          if (miss) begin
            // addr_q is frozen until the replay; the in-flight request is dropped.
            // The victim line is invalidated up front so a half-written line never looks valid.
            req_q          <= 1'b0;
            beat           <= '0;
            valid_q[q_idx] <= 1'b0;
            mem.mem_req    <= 1'b1;
            mem.mem_addr   <= line_base(addr_q, OW);
          end else begin
            req_q <= fetch_enable;
            if (fetch_enable) addr_q <= fetch_addr;
            if (fetch_valid) instr_q <= rd_word;
          end
        end
        REFILL: begin
          if (ack_take) begin
            beat <= beat + OW'(1);
            if (last_beat) begin
              valid_q[q_idx] <= 1'b1;
              mem.mem_req    <= 1'b0;
            end else begin
              mem.mem_addr <= mem.mem_addr + 32'd4;
            end
          end
        end
        REPLAY: req_q <= 1'b1;
        default: req_q <= 1'b0;
      endcase
    end
  end

  icache_line_ram #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .TW         (TW)
  ) u_ram (
    .CLK       (CLK),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .rd_off    (rd_off),
    .rd_word   (rd_word),
    .rd_tag    (rd_tag),
    .wr_en     (ack_take),
    .wr_idx    (q_idx),
    .wr_off    (beat),
    .wr_word   (mem.mem_rdata),
    .tag_we    (last_beat),
    .tag_wdata (q_tag)
  );

`ifdef ICACHE_PERF_EN
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (fetch_valid) hit_count  <= hit_count + 32'd1;
      if (miss)        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
module tb_icache_fetch;

  localparam int          SETS = 64;
  localparam int          LW   = 4;
  localparam logic [31:0] RST  = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_enable = 1'b0;
  logic [31:0] instr_fetch;
  logic        fetch_valid;
  logic        busy;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_fetch_if mif ();

  icache_fetch #(.SETS(SETS), .LINE_WORDS(LW), .RESET_ADDR(RST)) dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .fetch_addr   (fetch_addr),
    .fetch_enable (fetch_enable),
    .instr_fetch  (instr_fetch),
    .fetch_valid  (fetch_valid),
    .busy         (busy),
    .mem          (mif)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int          tests = 0;
  int          fails = 0;
  int          ack_mode = 0;   // 0: every cycle, 1: every 3rd cycle, 2: random
  logic [31:0] acked[$];       // addresses the memory acknowledged, in order

  // Reference model: which memory line each set currently holds.
  bit          m_valid [SETS];
  logic [31:0] m_line  [SETS];
  int          m_hits = 0;
  int          m_misses = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h1000: return 32'h0000_0013;
      32'h1004: return 32'h0010_0093;
      32'h1008: return 32'h0020_0113;
      32'h100C: return 32'h0030_0193;
      default:  return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a / (LW * 4);
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'(line_of(a) % SETS);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_perf(input string tag);
`ifdef ICACHE_PERF_EN
    check({tag, "_hits"}, hit_count, m_hits);
    check({tag, "_misses"}, miss_count, m_misses);
`else
    tag = tag;
`endif
  endtask

  // Memory responder: acks according to ack_mode, returns memfn(mem_addr);
  // throws in spurious acks while no request is outstanding.
  initial begin
    int cnt;
    bit go;
    cnt = 0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
    forever begin
      tick();
      if (mif.mem_req) begin
        cnt++;
        case (ack_mode)
          0:       go = 1'b1;
          1:       go = (cnt % 3 == 0);
          default: go = 1'($urandom_range(0, 1));
        endcase
        if (go) acked.push_back(mif.mem_addr);
        mif.mem_ack   = go;
        mif.mem_rdata = go ? memfn(mif.mem_addr) : $urandom;
      end else begin
        cnt           = 0;
        mif.mem_ack   = ($urandom_range(0, 3) == 0);
        mif.mem_rdata = $urandom;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  // Cycle after a returned word with fetch_enable low: valid drops, word holds.
  task automatic after_valid(input logic [31:0] a);
    tick();
    @(negedge CLK);
    check("valid_drops", fetch_valid, 1'b0);
    check("instr_hold", instr_fetch, memfn(a));
    tick();
  endtask

  // Called in the miss-detect cycle (before its negedge).
  task automatic await_miss(input logic [31:0] a, input bit fast, input bit toggle);
    int n, r;
    bit got, busy_ok, early;
    n = 0; r = 0; got = 0; busy_ok = 1; early = 0;
    acked.delete();
    while (n < 100) begin
      @(negedge CLK);
      if (fetch_valid) begin
        got = 1;
        break;
      end
      if (mif.mem_req) begin
        r++;
        if (!busy) busy_ok = 0;
        if (n == 0) early = 1;
      end
      tick();
      if (toggle && mif.mem_req) begin
        fetch_enable = 1'($urandom_range(0, 1));
        fetch_addr   = $urandom_range(0, 1) ? 32'h0000_2000 : a;
      end else begin
        fetch_enable = 1'b0;
        fetch_addr   = a;
      end
      n++;
    end
    check("miss_valid", got, 1'b1);
    check("miss_latency", n, r + 2);
    if (fast) check("refill_cycles", r, LW);
    check("beat_count", acked.size(), LW);
    for (int i = 0; i < LW && i < acked.size(); i++)
      check("beat_addr", acked[i], line_of(a) * (LW * 4) + 4 * i);
    check("busy_in_refill", busy_ok, 1'b1);
    check("no_req_at_detect", early, 1'b0);
    check("miss_data", instr_fetch, memfn(a));
    check("req_low_at_valid", mif.mem_req, 1'b0);
    m_valid[set_of(a)] = 1'b1;
    m_line[set_of(a)]  = line_of(a);
    m_misses++;
    m_hits++;
    after_valid(a);
  endtask

  task automatic fetch(input logic [31:0] a, input bit toggle);
    bit h;
    h = m_valid[set_of(a)] && (m_line[set_of(a)] == line_of(a));
    fetch_enable = 1'b1;
    fetch_addr   = a;
    tick();
    if (h) begin
      fetch_enable = 1'b0;
      @(negedge CLK);
      check("hit_valid", fetch_valid, 1'b1);
      check("hit_data", instr_fetch, memfn(a));
      check("hit_no_req", mif.mem_req, 1'b0);
      m_hits++;
      after_valid(a);
    end else begin
      await_miss(a, ack_mode == 0, toggle);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", fetch_valid, 1'b0);
    check("rst_instr", instr_fetch, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_req", mif.mem_req, 1'b0);
    check("rst_addr", mif.mem_addr, 32'h0);
    check_perf("rst_perf");
  endtask

  initial begin
    logic [31:0] seq[3];
    logic [31:0] pool[6];
    int n;
    seq[0] = 32'h1004; seq[1] = 32'h1008; seq[2] = 32'h100C;
    pool[0] = 32'h1000; pool[1] = 32'h1400; pool[2] = 32'h1010;
    pool[3] = 32'h2000; pool[4] = 32'h1230; pool[5] = 32'h7FF0;

    // Reset state, then cold start: auto lookup of RESET_ADDR misses and fills.
    model_reset();
    #2;
    check_reset_outputs();
    tick();
    tick();
    resetn = 1'b1;
    await_miss(RST, 1'b1, 1'b0);
    check_perf("cold_perf");

    // Back-to-back hits within the filled line.
    fetch_enable = 1'b1;
    fetch_addr   = seq[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) fetch_addr = seq[i + 1];
      else fetch_enable = 1'b0;
      @(negedge CLK);
      check("seq_valid", fetch_valid, 1'b1);
      check("seq_data", instr_fetch, memfn(seq[i]));
      check("seq_no_req", mif.mem_req, 1'b0);
      m_hits++;
    end
    after_valid(seq[2]);

    // Conflict: same index, different tag, evicts and then is evicted.
    fetch(32'h1000 + SETS * LW * 4, 1'b0);
    fetch(32'h1000, 1'b0);

    // Slow memory with the requester wiggling its inputs during the refill.
    ack_mode = 1;
    fetch(32'h1234, 1'b1);
    ack_mode = 0;

    // Randomized fetches over a few aliasing lines and memory speeds.
    for (int k = 0; k < 40; k++) begin
      ack_mode = $urandom_range(0, 2);
      fetch(pool[$urandom_range(0, 5)] + 4 * $urandom_range(0, LW - 1), 1'($urandom_range(0, 1)));
    end
    ack_mode = 0;
    check_perf("random_perf");

    // Reset in the middle of a refill, after two beats have landed.
    fetch_enable = 1'b1;
    fetch_addr   = 32'h5020;
    tick();
    fetch_enable = 1'b0;
    acked.delete();
    n = 0;
    while (acked.size() < 2 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("two_beats_seen", acked.size() >= 2, 1'b1);
    @(posedge CLK);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    tick();
    tick();
    resetn = 1'b1;
    await_miss(RST, 1'b1, 1'b0);
    check_perf("post_reset_perf");
    fetch(32'h5020, 1'b0);
    fetch(32'h5024, 1'b0);
    check_perf("final_perf");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Instruction-side responder for the core fetch interface.
- Accepts a fetch address and enable from the main controller. Returns the instruction word with `fetch_valid` one cycle later on a hit.
- On a miss, refills a direct-mapped line from the instruction memory bus over a req/ack handshake, then replays the lookup.
- Sits between the main controller and the instruction memory port.

Parameters:
- SETS, 64, number of cache lines (power of 2).
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2).
- RESET_ADDR, 32'h00001000, address whose lookup is auto-issued on the first cycle after reset.

Ports:
- CLK  in  1  clock
- resetn  in  1  asynchronous active-low reset
- fetch_addr  in  32  instruction address; bits [1:0] ignored
- fetch_enable  in  1  lookup request for `fetch_addr` this cycle
- instr_fetch  out  32  instruction for the last accepted address
- fetch_valid  out  1  `instr_fetch` valid this cycle
- busy  out  1  refill in progress; lookups are ignored
- mem_req  out  1  memory read request
- mem_addr  out  32  word-aligned memory read address
- mem_ack  in  1  memory returns `mem_rdata` for `mem_addr` this cycle
- mem_rdata  in  32  memory read data

Behaviour:
- Address split:
  - offset = `addr[2 +: log2(LINE_WORDS)]`
  - index = next `log2(SETS)` bits
  - tag = remaining upper bits
- Arrays:
  - Data and tag arrays use synchronous read, written only by refill, not reset.
  - Per-line valid bits are flops, cleared by reset.
- FSM states: RUN, REFILL, REPLAY. Reset state is RUN.
- Reset values:
  - `fetch_valid`=0, `instr_fetch`=0, `busy`=0, `mem_req`=0, `mem_addr`=0, all valid bits 0.
  - `req_q`=1, `addr_q`=RESET_ADDR, so the first post-reset cycle performs a lookup of RESET_ADDR.
- RUN:
  - Each cycle, arrays are read at `fetch_addr` index when `fetch_enable`=1.
  - `req_q` <= `fetch_enable`; `addr_q` <= `fetch_addr` when enabled.
  - Cycle after an accepted request, compare the stored tag with `addr_q` tag:
    - hit (valid & tag match): `fetch_valid`=1, `instr_fetch`=word at `addr_q` offset. Latency 1 cycle.
    - miss: `fetch_valid`=0; go to REFILL. The request in flight this cycle is discarded; the requester holds its address while `fetch_valid`=0.
  - `req_q`=0: `fetch_valid`=0; `instr_fetch` holds its last value.
- REFILL:
  - `busy`=1, `fetch_valid`=0, `mem_req`=1.
  - `mem_addr` = line base of `addr_q` + 4×beat; beat counter runs 0..LINE_WORDS-1.
  - On `mem_ack`, write `mem_rdata` to data[index][beat] and increment beat. `mem_addr` advances the following cycle.
  - `mem_ack` in the first REFILL cycle is legal.
  - On the last-beat ack:
    - write tag, set valid[index];
    - `mem_req`=0 from the next cycle;
    - go to REPLAY.
  - `fetch_enable` and `fetch_addr` are ignored throughout REFILL.
- REPLAY:
  - One cycle; arrays are read at `addr_q` index.
  - Go to RUN with `req_q`=1, so the next cycle hits and raises `fetch_valid`.
- Miss-to-valid latency = 1 (detect) + N (ack cycles) + 1 (REPLAY) + 1.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset asserted mid-refill:
  - immediately: `mem_req`=0, RUN, all lines invalid;
  - a partially written line is never marked valid.
- Index aliasing: a refill replaces the line unconditionally. There is no write path from the core, so no coherence handling.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined:
  - Adds outputs `hit_count` [31:0] and `miss_count` [31:0].
  - Each increments once per RUN compare cycle with `req_q`=1 (hit or miss respectively).
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package icache_pkg:
  - state enum (RUN, REFILL, REPLAY);
  - localparams for offset, index and tag widths derived from SETS/LINE_WORDS;
  - address-field extraction functions.
- One sub-module: icache_line_ram (synchronous-read data + tag storage, one write port, one read port).
- FSM, valid bits and memory handshake stay in icache_fetch.

Test Plan:
- Cold start:
  - Release reset; memory returns 0x00000013, 0x00100093, 0x00200113, 0x00300193 for 0x1000-0x100C with `mem_ack` every cycle.
  - Required: `mem_req` for base 0x1000; four beats; REPLAY; `fetch_valid`=1 with `instr_fetch`=0x00000013 on cycle 7 after reset release.
- Sequential hits:
  - After the cold fill, enable with addresses 0x1004, 0x1008, 0x100C on consecutive cycles.
  - Required: `fetch_valid`=1 on each following cycle, returning 0x00100093, 0x00200113, 0x00300193; `mem_req` stays 0.
- Conflict miss:
  - Fetch 0x1000 + SETS×LINE_WORDS×4 (0x1400 with defaults).
  - Required: miss, refill at base 0x1400, REPLAY, `fetch_valid` with new data.
  - Then re-fetch 0x1000: must miss again.
- Slow memory and stall:
  - `mem_ack` every 3rd cycle; toggle `fetch_addr` to 0x2000 during REFILL.
  - Required: refill address unchanged, toggled inputs ignored, `fetch_valid`=1 only after REPLAY.
- `fetch_enable`=0 after a hit:
  - Required: `fetch_valid`=0 next cycle; `instr_fetch` holds its previous value.
- Reset after beat 2 of a refill:
  - Required: `mem_req`=0 immediately; later fetch of the same line misses and fully refills.
  - With ICACHE_PERF_EN: counters read 0 after reset, and one hit plus one miss read 1/1.
